// File: rtl/picorv32_posted_write_buffer_if.sv
// ---------------------------------------------------------------------------
// picorv32_posted_write_buffer_if
// PicoRV32 native memory port bundle. Used twice by the posted write buffer:
// once towards the core and once towards the downstream adapter.
//   mem_valid / mem_ready : request / completion handshake
//   mem_instr             : instruction fetch flag
//   mem_addr / mem_wdata  : address and write data
//   mem_wstrb             : byte strobes, 4'b0000 marks a read
//   mem_rdata             : read data, valid while mem_ready is high
// Modports: master issues requests, slave answers them.
// ---------------------------------------------------------------------------
interface picorv32_posted_write_buffer_if;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/picorv32_posted_write_buffer.sv
// ---------------------------------------------------------------------------
// picorv32_posted_write_buffer
// Posts core writes into a DEPTH-entry FIFO and acknowledges them after one
// cycle, then drains them in order to the downstream adapter. Reads wait
// until every older write has drained and then pass through downstream.
//
// Ports:
//   clk        : clock, everything on the rising edge
//   reset      : synchronous, active-high
//   core       : slave side of the native port, connected to the core
//   dn         : master side of the native port, connected to the adapter
//   wbuf_count : number of buffered writes (0..DEPTH)
//   wbuf_empty : no buffered writes and no downstream write in flight
//
// Optional feature macro: PICORV_WBUF_READ_FORWARD_EN
//   When defined, a read hitting a buffered full-word write (newest match)
//   returns that data in one cycle without a downstream access.
// ---------------------------------------------------------------------------
module picorv32_posted_write_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   picorv32_posted_write_buffer_if.slave         core,
   picorv32_posted_write_buffer_if.master        dn,
   output logic [PTR_W:0]                        wbuf_count,
   output logic                                  wbuf_empty
);

   typedef enum logic [1:0] {C_IDLE, C_RD_WAIT, C_ACK, C_HOLD} c_state_t;
   typedef enum logic [1:0] {D_IDLE, D_WRITE, D_READ, D_GAP}   d_state_t;

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   logic [31:0] fifo_addr_q  [DEPTH];
   logic [31:0] fifo_wdata_q [DEPTH];
   logic [3:0]  fifo_wstrb_q [DEPTH];
   logic        fifo_instr_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   c_state_t         c_state_q, c_state_d;
   d_state_t         d_state_q, d_state_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             dn_valid_q, dn_valid_d;
   logic             dn_instr_q, dn_instr_d;
   logic [31:0]      dn_addr_q, dn_addr_d;
   logic [31:0]      dn_wdata_q, dn_wdata_d;
   logic [3:0]       dn_wstrb_q, dn_wstrb_d;
   logic             push, pop;
   logic             fwd_hit;
   logic [31:0]      fwd_data;

`ifdef PICORV_WBUF_READ_FORWARD_EN
   logic             fwd_seen, fwd_full;
   logic [PTR_W-1:0] fwd_idx;

   // Walk oldest to newest so the last match (newest write) wins; a partial
   // strobe newest match disables forwarding and the read waits for drain.
   always_comb begin
      fwd_seen = 1'b0;
      fwd_full = 1'b0;
      fwd_data = '0;
      fwd_idx  = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_q) &&
             (fifo_addr_q[fwd_idx][31:2] == core.mem_addr[31:2])) begin
            fwd_seen = 1'b1;
            fwd_full = (fifo_wstrb_q[fwd_idx] == 4'b1111);
            fwd_data = fifo_wdata_q[fwd_idx];
         end
      end
      fwd_hit = fwd_seen & fwd_full;
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   // Core-side FSM: accepts one request, acks it, then waits for valid low.
   always_comb begin
      c_state_d = c_state_q;
      push      = 1'b0;
      rdata_d   = rdata_q;
      case (c_state_q)
         C_IDLE: begin
            if (core.mem_valid) begin
               if (core.mem_wstrb != 4'b0000) begin
                  if (count_q != FULL_CNT) begin
                     push      = 1'b1;
                     c_state_d = C_ACK;
                  end
               end else if (fwd_hit) begin
                  rdata_d   = fwd_data;
                  c_state_d = C_ACK;
               end else begin
                  c_state_d = C_RD_WAIT;
               end
            end
         end
         C_RD_WAIT: begin
            if ((d_state_q == D_READ) && dn.mem_ready) begin
               rdata_d   = dn.mem_rdata;
               c_state_d = C_ACK;
            end
         end
         C_ACK:   c_state_d = C_HOLD;
         C_HOLD:  if (!core.mem_valid) c_state_d = C_IDLE;
         default: c_state_d = C_IDLE;
      endcase
   end

   // Downstream FSM: buffered writes first, then a pending read. A write
   // pushed into an empty FIFO is launched on the same edge from the core
   // inputs, since the head slot is only written at that edge.
   always_comb begin
      d_state_d  = d_state_q;
      pop        = 1'b0;
      dn_valid_d = dn_valid_q;
      dn_instr_d = dn_instr_q;
      dn_addr_d  = dn_addr_q;
      dn_wdata_d = dn_wdata_q;
      dn_wstrb_d = dn_wstrb_q;
      case (d_state_q)
         D_IDLE: begin
            if (count_q != '0) begin
               dn_valid_d = 1'b1;
               dn_instr_d = fifo_instr_q[rd_ptr_q];
               dn_addr_d  = fifo_addr_q[rd_ptr_q];
               dn_wdata_d = fifo_wdata_q[rd_ptr_q];
               dn_wstrb_d = fifo_wstrb_q[rd_ptr_q];
               d_state_d  = D_WRITE;
            end else if (push) begin
               dn_valid_d = 1'b1;
               dn_instr_d = core.mem_instr;
               dn_addr_d  = core.mem_addr;
               dn_wdata_d = core.mem_wdata;
               dn_wstrb_d = core.mem_wstrb;
               d_state_d  = D_WRITE;
            end else if (c_state_q == C_RD_WAIT) begin
               dn_valid_d = 1'b1;
               dn_instr_d = core.mem_instr;
               dn_addr_d  = core.mem_addr;
               dn_wstrb_d = 4'b0000;
               d_state_d  = D_READ;
            end
         end
         D_WRITE: begin
            if (dn.mem_ready) begin
               pop        = 1'b1;
               dn_valid_d = 1'b0;
               d_state_d  = D_GAP;
            end
         end
         D_READ: begin
            if (dn.mem_ready) begin
               dn_valid_d = 1'b0;
               d_state_d  = D_GAP;
            end
         end
         D_GAP:   d_state_d = D_IDLE;
         default: d_state_d = D_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_state_q  <= C_IDLE;
         d_state_q  <= D_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
         dn_valid_q <= 1'b0;
         dn_instr_q <= 1'b0;
         dn_addr_q  <= '0;
         dn_wdata_q <= '0;
         dn_wstrb_q <= '0;
      end else begin
         c_state_q  <= c_state_d;
         d_state_q  <= d_state_d;
         count_q    <= count_d;
         rdata_q    <= rdata_d;
         dn_valid_q <= dn_valid_d;
         dn_instr_q <= dn_instr_d;
         dn_addr_q  <= dn_addr_d;
         dn_wdata_q <= dn_wdata_d;
         dn_wstrb_q <= dn_wstrb_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Entry storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q]  <= core.mem_addr;
         fifo_wdata_q[wr_ptr_q] <= core.mem_wdata;
         fifo_wstrb_q[wr_ptr_q] <= core.mem_wstrb;
         fifo_instr_q[wr_ptr_q] <= core.mem_instr;
      end
   end

   assign core.mem_ready = (c_state_q == C_ACK);
   assign core.mem_rdata = rdata_q;
   assign dn.mem_valid   = dn_valid_q;
   assign dn.mem_instr   = dn_instr_q;
   assign dn.mem_addr    = dn_addr_q;
   assign dn.mem_wdata   = dn_wdata_q;
   assign dn.mem_wstrb   = dn_wstrb_q;
   assign wbuf_count     = count_q;
   assign wbuf_empty     = (count_q == '0) && (d_state_q != D_WRITE);

endmodule

// File: tb/tb_picorv32_posted_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_picorv32_posted_write_buffer
// Directed bench for the posted write buffer: a core-side driver, a
// downstream responder with programmable latency and a ready budget, and a
// log of every downstream transaction for ordering checks.
// ---------------------------------------------------------------------------
module tb_picorv32_posted_write_buffer;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [PTR_W:0] wbuf_count;
   logic           wbuf_empty;

   always #5 clk = ~clk;

   picorv32_posted_write_buffer_if core_if();
   picorv32_posted_write_buffer_if dn_if();

   picorv32_posted_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .core       (core_if),
      .dn         (dn_if),
      .wbuf_count (wbuf_count),
      .wbuf_empty (wbuf_empty)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_cnt = 0;
   int rdy_allowed = 0;
   int rdy_given = 0;
   int dn_delay = 0;
   logic [31:0] dn_rd_val = 32'h0;

   logic [31:0] log_addr  [$];
   logic [31:0] log_wdata [$];
   logic [3:0]  log_wstrb [$];
   int          log_start [$];
   int          log_end   [$];

   logic [31:0]    sn_dna;
   logic           sn_dnv, sn_empty;
   logic [PTR_W:0] sn_cnt;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (core_if.mem_ready) rdy_cnt++;
      end
   end

   // Downstream responder: ready after dn_delay waiting cycles, one pulse per
   // transaction, only while rdy_given < rdy_allowed.
   initial begin
      bit in_txn;
      int wcnt;
      int t_start;
      in_txn = 1'b0;
      wcnt = 0;
      t_start = 0;
      dn_if.mem_ready = 1'b0;
      dn_if.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            dn_if.mem_ready = 1'b0;
            in_txn = 1'b0;
         end else if (dn_if.mem_ready) begin
            dn_if.mem_ready = 1'b0;
         end else if (dn_if.mem_valid) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               wcnt = 0;
               t_start = cyc;
            end
            if ((rdy_given < rdy_allowed) && (wcnt >= dn_delay)) begin
               dn_if.mem_ready = 1'b1;
               dn_if.mem_rdata = dn_rd_val;
               rdy_given++;
               log_addr.push_back(dn_if.mem_addr);
               log_wdata.push_back(dn_if.mem_wdata);
               log_wstrb.push_back(dn_if.mem_wstrb);
               log_start.push_back(t_start);
               log_end.push_back(cyc);
               in_txn = 1'b0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic core_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] rd, output int lat);
      core_if.mem_valid = 1'b1;
      core_if.mem_instr = 1'b0;
      core_if.mem_addr  = a;
      core_if.mem_wdata = d;
      core_if.mem_wstrb = s;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!core_if.mem_ready && lat < 200);
      chk("ack_seen", {31'b0, core_if.mem_ready}, 32'd1);
      rd       = core_if.mem_rdata;
      sn_dnv   = dn_if.mem_valid;
      sn_dna   = dn_if.mem_addr;
      sn_cnt   = wbuf_count;
      sn_empty = wbuf_empty;
      core_if.mem_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(wbuf_empty && !dn_if.mem_valid && !dn_if.mem_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drained", {31'b0, wbuf_empty}, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!core_if.mem_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'b0, core_if.mem_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      int lat;
      int base;
      int r0;

      core_if.mem_valid = 1'b0;
      core_if.mem_instr = 1'b0;
      core_if.mem_addr  = '0;
      core_if.mem_wdata = '0;
      core_if.mem_wstrb = '0;

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, core_if.mem_ready}, 32'd0);
      chk("rst_rdata", core_if.mem_rdata, 32'd0);
      chk("rst_dn_valid", {31'b0, dn_if.mem_valid}, 32'd0);
      chk("rst_dn_addr", dn_if.mem_addr, 32'd0);
      chk("rst_dn_wstrb", {28'b0, dn_if.mem_wstrb}, 32'd0);
      chk("rst_count", {29'b0, wbuf_count}, 32'd0);
      chk("rst_empty", {31'b0, wbuf_empty}, 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Single write, downstream ready after 4 waiting cycles (valid 5 cycles)
      rdy_allowed = rdy_given + 1000;
      dn_delay = 4;
      base = log_addr.size();
      core_access(32'h1000, 32'hDEADBEEF, 4'hF, rd, lat);
      chk("t1_lat", lat, 32'd1);
      chk("t1_dn_valid", {31'b0, sn_dnv}, 32'd1);
      chk("t1_dn_addr", sn_dna, 32'h1000);
      chk("t1_count", {29'b0, sn_cnt}, 32'd1);
      chk("t1_empty", {31'b0, sn_empty}, 32'd0);
      wait_idle();
      chk("t1_ntx", log_addr.size() - base, 32'd1);
      chk("t1_addr", log_addr[base], 32'h1000);
      chk("t1_wdata", log_wdata[base], 32'hDEADBEEF);
      chk("t1_wstrb", {28'b0, log_wstrb[base]}, 32'hF);
      chk("t1_vld_len", log_end[base] - log_start[base], 32'd4);

      // Fill to DEPTH with downstream stalled; fifth write must stall
      dn_delay = 0;
      rdy_allowed = rdy_given;
      base = log_addr.size();
      for (int i = 0; i < 4; i++) begin
         core_access(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, rd, lat);
         chk("t2_lat", lat, 32'd1);
      end
      chk("t2_full", {29'b0, wbuf_count}, 32'd4);
      r0 = rdy_cnt;
      core_if.mem_valid = 1'b1;
      core_if.mem_addr  = 32'h2010;
      core_if.mem_wdata = 32'hA4;
      core_if.mem_wstrb = 4'hF;
      repeat (6) @(negedge clk);
      chk("t2_stall_ready", {31'b0, core_if.mem_ready}, 32'd0);
      chk("t2_stall_pulses", rdy_cnt - r0, 32'd0);
      chk("t2_stall_count", {29'b0, wbuf_count}, 32'd4);
      rdy_allowed = rdy_given + 1;
      wait_ready();
      chk("t2_ack5_count", {29'b0, wbuf_count}, 32'd4);
      core_if.mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t2_one_drained", log_addr.size() - base, 32'd1);
      rdy_allowed = rdy_given + 1000;
      wait_idle();
      chk("t2_ntx", log_addr.size() - base, 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_order", log_addr[base + i], 32'h2000 + 32'(4 * i));
      end

`ifdef PICORV_WBUF_READ_FORWARD_EN
      // Read forwarding from a buffered full-word write
      rdy_allowed = rdy_given;
      dn_delay = 0;
      base = log_addr.size();
      core_access(32'h4000, 32'hCAFEF00D, 4'hF, rd, lat);
      core_access(32'h4000, 32'h0, 4'h0, rd, lat);
      chk("t4_fwd_lat", lat, 32'd1);
      chk("t4_fwd_data", rd, 32'hCAFEF00D);
      chk("t4_no_dn", log_addr.size() - base, 32'd0);
      dn_rd_val = 32'h0BADF00D;
      core_if.mem_valid = 1'b1;
      core_if.mem_addr  = 32'h4004;
      core_if.mem_wstrb = 4'h0;
      repeat (4) @(negedge clk);
      chk("t4_miss_waits", {31'b0, core_if.mem_ready}, 32'd0);
      rdy_allowed = rdy_given + 1000;
      wait_ready();
      chk("t4_miss_data", core_if.mem_rdata, 32'h0BADF00D);
      core_if.mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      wait_idle();
      chk("t4_ntx", log_addr.size() - base, 32'd2);
      chk("t4_rd_addr", log_addr[base + 1], 32'h4004);
      chk("t4_rd_wstrb", {28'b0, log_wstrb[base + 1]}, 32'h0);
`else
      // Read after write waits for the drain, then goes downstream
      rdy_allowed = rdy_given + 1000;
      dn_delay = 2;
      dn_rd_val = 32'h55667788;
      base = log_addr.size();
      core_access(32'h3000, 32'h11223344, 4'hF, rd, lat);
      core_access(32'h3000, 32'h0, 4'h0, rd, lat);
      chk("t3_rdata", rd, 32'h55667788);
      wait_idle();
      chk("t3_ntx", log_addr.size() - base, 32'd2);
      chk("t3_wr_first", {28'b0, log_wstrb[base]}, 32'hF);
      chk("t3_wr_data", log_wdata[base], 32'h11223344);
      chk("t3_rd_addr", log_addr[base + 1], 32'h3000);
      chk("t3_rd_wstrb", {28'b0, log_wstrb[base + 1]}, 32'h0);
      chk("t3_gap", {31'b0, (log_start[base + 1] - log_end[base]) >= 2}, 32'd1);
`endif

      // Reset with three buffered writes and one in flight
      rdy_allowed = rdy_given;
      dn_delay = 0;
      base = log_addr.size();
      for (int i = 0; i < 3; i++) begin
         core_access(32'h5000 + 32'(4 * i), 32'h50 + 32'(i), 4'hF, rd, lat);
      end
      chk("t5_count3", {29'b0, wbuf_count}, 32'd3);
      chk("t5_inflight", {31'b0, dn_if.mem_valid}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_dn_valid", {31'b0, dn_if.mem_valid}, 32'd0);
      chk("t5_count", {29'b0, wbuf_count}, 32'd0);
      chk("t5_empty", {31'b0, wbuf_empty}, 32'd1);
      chk("t5_ready", {31'b0, core_if.mem_ready}, 32'd0);
      reset = 1'b0;
      rdy_allowed = rdy_given + 1000;
      repeat (6) @(negedge clk);
      chk("t5_discarded", log_addr.size() - base, 32'd0);

      // Core holds valid for 3 cycles after the ack
      base = log_addr.size();
      r0 = rdy_cnt;
      core_if.mem_valid = 1'b1;
      core_if.mem_addr  = 32'h6000;
      core_if.mem_wdata = 32'h66;
      core_if.mem_wstrb = 4'hF;
      wait_ready();
      repeat (3) @(negedge clk);
      core_if.mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      wait_idle();
      chk("t6_pulses", rdy_cnt - r0, 32'd1);
      chk("t6_ntx", log_addr.size() - base, 32'd1);
      chk("t6_addr", log_addr[base], 32'h6000);
      chk("t6_count", {29'b0, wbuf_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
